// File: rtl/udp_sched_pkg.sv
// rtl/udp_sched_pkg.sv - shared types and round-robin pick for the UDP TX scheduler
package udp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } sched_state_e;

  localparam int RR_MAX_CH = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping within the lowest n channels.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] valid,
                                       input logic [2:0] ptr,
                                       input int n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int i = 0; i < RR_MAX_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      if ((i < n) && !r.found && valid[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: combinational pick, registered pointer
module rr_arbiter
  import udp_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] i_valid,
  input  logic              i_advance,
  output logic              o_found,
  output logic [IDX_W-1:0]  o_grant
);

  logic [IDX_W-1:0]     r_ptr;
  logic [RR_MAX_CH-1:0] w_valid8;
  logic [2:0]           w_ptr3;
  rr_pick_t             w_pick;

  always_comb begin
    w_valid8              = '0;
    w_valid8[NUM_CH-1:0]  = i_valid;
    w_ptr3                = '0;
    w_ptr3[IDX_W-1:0]     = r_ptr;
  end

  assign w_pick  = rr_pick(w_valid8, w_ptr3, NUM_CH);
  assign o_found = w_pick.found;
  assign o_grant = w_pick.idx[IDX_W-1:0];

  // The granted channel drops to lowest priority for the next round.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (i_advance && w_pick.found) begin
      r_ptr <= (o_grant == IDX_W'(NUM_CH - 1)) ? '0 : o_grant + 1'b1;
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// rtl/udp_tx_scheduler.sv - round-robin sharing of one UDP transmitter among NUM_CH requesters
module udp_tx_scheduler
  import udp_sched_pkg::*;
#(
  parameter  int          NUM_CH       = 4,
  parameter  int          DATA_BYTES   = 16,
  parameter  logic [15:0] BASE_PORT    = 16'h1000,
  parameter  int          GAP_CYCLES   = 32,
  parameter  int          BUSY_TIMEOUT = 64,
  localparam int          IDX_W        = $clog2(NUM_CH),
  localparam int          DW           = 8 * DATA_BYTES
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] req_valid,
  input  logic [DW-1:0]     req_data [NUM_CH],
  output logic [NUM_CH-1:0] req_ack,
  input  logic              tx_ready,
  output logic              tx_send,
  output logic [DW-1:0]     tx_data,
  output logic [15:0]       tx_dest_port,
  output logic [IDX_W-1:0]  grant_id,
  output logic              busy,
  output logic              err_timeout,
  output logic [31:0]       pkt_count
);

  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [15:0]       r_cnt;
  logic [NUM_CH-1:0] r_ack;
  logic              r_tx_send;
  logic [DW-1:0]     r_tx_data;
  logic [15:0]       r_port;
  logic [IDX_W-1:0]  r_grant;
  logic              r_err;
  logic [31:0]       r_pkt;

  logic              w_found;
  logic [IDX_W-1:0]  w_grant;
  logic              w_grant_en;
  logic              w_timeout;
  logic              w_done;
  logic              w_cnt_clr;
  logic              w_cnt_inc;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   (req_valid),
    .i_advance (w_grant_en),
    .o_found   (w_found),
    .o_grant   (w_grant)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // One counter serves both the ISSUE timeout and the GAP length.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_ready && w_found) begin
          w_grant_en  = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_ready) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_cnt == BUSY_LAST) begin
          w_timeout   = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = GAP;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          w_done      = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) w_state_nxt = IDLE;
        else                   w_cnt_inc   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_ack     <= '0;
      r_tx_send <= 1'b0;
      r_tx_data <= '0;
      r_port    <= BASE_PORT;
      r_grant   <= '0;
      r_err     <= 1'b0;
      r_pkt     <= '0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 16'd1;

      r_ack <= '0;
      r_err <= w_timeout;
      if (w_done) r_pkt <= r_pkt + 32'd1;

      if (w_grant_en) begin
        r_ack[w_grant] <= 1'b1;
        r_tx_send      <= 1'b1;
        r_tx_data      <= req_data[w_grant];
        r_port         <= BASE_PORT + 16'(w_grant);
        r_grant        <= w_grant;
      end else if (r_state == ISSUE && w_state_nxt != ISSUE) begin
        r_tx_send      <= 1'b0;
      end
    end
  end

  assign req_ack      = r_ack;
  assign tx_send      = r_tx_send;
  assign tx_data      = r_tx_data;
  assign tx_dest_port = r_port;
  assign grant_id     = r_grant;
  assign busy         = (r_state != IDLE);
  assign err_timeout  = r_err;
  assign pkt_count    = r_pkt;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb/tb_udp_tx_scheduler.sv - directed self-checking bench for udp_tx_scheduler
module tb_udp_tx_scheduler;

  localparam logic [127:0] P = 128'h0F0E0D0C0B0A09080706050403020100;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   req_valid;
  logic [127:0] req_data [4];
  logic [3:0]   req_ack;
  logic         tx_ready;
  logic         tx_send;
  logic [127:0] tx_data;
  logic [15:0]  tx_dest_port;
  logic [1:0]   grant_id;
  logic         busy;
  logic         err_timeout;
  logic [31:0]  pkt_count;

  int checks   = 0;
  int failures = 0;

  udp_tx_scheduler dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .tx_ready     (tx_ready),
    .tx_send      (tx_send),
    .tx_data      (tx_data),
    .tx_dest_port (tx_dest_port),
    .grant_id     (grant_id),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input int ch);
    return P ^ (128'(ch) << 124);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (req_ack == 4'b0 && cyc < max_cyc);
    chk("ack_seen", 128'(req_ack != 4'b0), 128'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 128'(busy), 128'd0);
  endtask

  task automatic serve(input int ch, input bit drop);
    int cyc;
    wait_ack(200, cyc);
    chk("serve_ack", 128'(req_ack), 128'(4'b1 << ch));
    chk("serve_grant", 128'(grant_id), 128'(ch));
    chk("serve_port", 128'(tx_dest_port), 128'(16'h1000 + ch));
    chk("serve_data", tx_data, pat(ch));
    chk("serve_send", 128'(tx_send), 128'd1);
    if (drop) req_valid[ch] = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("serve_send_low", 128'(tx_send), 128'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    wait_idle();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"},   128'(req_ack), 128'd0);
    chk({tag, "_send"},  128'(tx_send), 128'd0);
    chk({tag, "_data"},  tx_data, 128'd0);
    chk({tag, "_port"},  128'(tx_dest_port), 128'h1000);
    chk({tag, "_grant"}, 128'(grant_id), 128'd0);
    chk({tag, "_busy"},  128'(busy), 128'd0);
    chk({tag, "_err"},   128'(err_timeout), 128'd0);
    chk({tag, "_pkt"},   128'(pkt_count), 128'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    int order [6] = '{0, 1, 2, 3, 0, 1};

    rstn      = 1'b0;
    req_valid = 4'b0;
    tx_ready  = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = pat(i);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Single request on channel 2, transmitter drops ready 3 cycles after send.
    req_valid = 4'b0100;
    wait_ack(10, cyc);
    chk("t1_latency", 128'(cyc), 128'd1);
    chk("t1_ack", 128'(req_ack), 128'b0100);
    chk("t1_port", 128'(tx_dest_port), 128'h1002);
    chk("t1_send", 128'(tx_send), 128'd1);
    chk("t1_data", tx_data, pat(2));
    req_valid = 4'b0;
    @(negedge clk);
    chk("t1_ack_pulse", 128'(req_ack), 128'd0);
    chk("t1_send_held1", 128'(tx_send), 128'd1);
    @(negedge clk);
    chk("t1_send_held2", 128'(tx_send), 128'd1);
    @(negedge clk);
    chk("t1_send_held3", 128'(tx_send), 128'd1);
    tx_ready = 1'b0;
    @(negedge clk);
    chk("t1_send_dropped", 128'(tx_send), 128'd0);
    chk("t1_busy_wait", 128'(busy), 128'd1);
    chk("t1_pkt_pending", 128'(pkt_count), 128'd0);
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t1_pkt_done", 128'(pkt_count), 128'd1);
    req_valid = 4'b0100;
    wait_ack(100, cyc);
    chk("t1_gap_latency", 128'(cyc), 128'd33);
    req_valid = 4'b0;
    tx_ready  = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    wait_idle();
    chk("t1_pkt_two", 128'(pkt_count), 128'd2);

    // Fairness with every channel continuously valid.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) serve(order[k], 1'b0);
    chk("t2_pkt_count", 128'(pkt_count), 128'd6);
    req_valid = 4'b0;

    // Transmitter never accepts: timeout after 64 cycles in ISSUE.
    req_valid = 4'b0001;
    wait_ack(10, cyc);
    chk("t3_ack", 128'(req_ack), 128'b0001);
    req_valid = 4'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!err_timeout && cyc < 100);
    chk("t3_timeout_latency", 128'(cyc), 128'd64);
    chk("t3_send_off", 128'(tx_send), 128'd0);
    chk("t3_pkt_same", 128'(pkt_count), 128'd6);
    chk("t3_busy_gap", 128'(busy), 128'd1);
    @(negedge clk);
    chk("t3_err_pulse", 128'(err_timeout), 128'd0);
    wait_idle();

    // Request while transmitter not ready: no ack until ready returns.
    tx_ready  = 1'b0;
    req_valid = 4'b0010;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= (req_ack != 4'b0);
    end
    chk("t4_no_ack", 128'(seen), 128'd0);
    chk("t4_idle", 128'(busy), 128'd0);
    tx_ready = 1'b1;
    serve(1, 1'b1);
    chk("t4_pkt", 128'(pkt_count), 128'd7);

    // Reset during WAIT_DONE, then pointer must be back at channel 0.
    req_valid = 4'b0100;
    wait_ack(10, cyc);
    chk("t5_ack", 128'(req_ack), 128'b0100);
    req_valid = 4'b0;
    tx_ready  = 1'b0;
    @(negedge clk);
    chk("t5_wait_busy", 128'(busy), 128'd1);
    chk("t5_wait_send", 128'(tx_send), 128'd0);
    rstn = 1'b0;
    #1;
    check_reset_vals("t5_async");
    @(negedge clk);
    rstn      = 1'b1;
    tx_ready  = 1'b1;
    req_valid = 4'b1001;
    wait_ack(10, cyc);
    chk("t5_ptr_reset_ack", 128'(req_ack), 128'b0001);
    chk("t5_ptr_reset_grant", 128'(grant_id), 128'd0);

    // Payload overwritten after ack must not disturb the latched data.
    req_data[0] = '1;
    req_valid   = 4'b0;
    chk("t6_data_ack", tx_data, P);
    @(negedge clk);
    chk("t6_data_issue", tx_data, P);
    tx_ready = 1'b0;
    @(negedge clk);
    chk("t6_data_wait", tx_data, P);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t6_pkt", 128'(pkt_count), 128'd1);
    wait_idle();
    chk("t6_data_idle", tx_data, P);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
